// File: rtl/subtrator_serial.sv
// Bit-serial unsigned subtractor: one full-subtractor cell plus a borrow flop,
// LSB first, LARGURA cycles per operation, with a one-cycle completion pulse.
module subtrator_serial #(
  parameter int LARGURA = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               iniciar,
  input  logic [LARGURA-1:0] numero1,
  input  logic [LARGURA-1:0] numero2,
  output logic [LARGURA-1:0] resultado,
  output logic               negativo,
  output logic               ocupado,
  output logic               pronto
);

  // Counter must be able to hold LARGURA itself so it never wraps mid-operation.
  localparam int CW = $clog2(LARGURA + 1);

  typedef enum logic [1:0] {
    OCIOSO    = 2'd0,
    CALCULA   = 2'd1,
    CONCLUIDO = 2'd2
  } estado_t;

  estado_t            estado_reg;
  logic [LARGURA-1:0] a_reg;
  logic [LARGURA-1:0] b_reg;
  logic [LARGURA-2:0] parcial_reg;
  logic               borrow_reg;
  logic [CW-1:0]      cont_reg;

  logic               dif_bit;
  logic               borrow_next;
  logic [LARGURA-2:0] parcial_next;
  logic               ultimo;

  always_comb begin
    dif_bit      = a_reg[0] ^ b_reg[0] ^ borrow_reg;
    borrow_next  = (~a_reg[0] & b_reg[0]) | (~(a_reg[0] ^ b_reg[0]) & borrow_reg);
    // Only the first LARGURA-1 bits are stored; the last bit goes straight
    // into resultado together with them on the completion edge.
    parcial_next              = parcial_reg >> 1;
    parcial_next[LARGURA-2]   = dif_bit;
    ultimo       = (cont_reg == CW'(LARGURA - 1));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_reg  <= OCIOSO;
      a_reg       <= '0;
      b_reg       <= '0;
      parcial_reg <= '0;
      borrow_reg  <= 1'b0;
      cont_reg    <= '0;
      resultado   <= '0;
      negativo    <= 1'b0;
      ocupado     <= 1'b0;
      pronto      <= 1'b0;
    end else begin
      case (estado_reg)
        OCIOSO: begin
          pronto <= 1'b0;
          if (iniciar) begin
            a_reg      <= numero1;
            b_reg      <= numero2;
            borrow_reg <= 1'b0;
            cont_reg   <= '0;
            ocupado    <= 1'b1;
            estado_reg <= CALCULA;
          end
        end
        CALCULA: begin
          a_reg       <= a_reg >> 1;
          b_reg       <= b_reg >> 1;
          borrow_reg  <= borrow_next;
          parcial_reg <= parcial_next;
          cont_reg    <= cont_reg + CW'(1);
          if (ultimo) begin
            resultado  <= {dif_bit, parcial_reg};
            negativo   <= borrow_next;
            pronto     <= 1'b1;
            estado_reg <= CONCLUIDO;
          end
        end
        CONCLUIDO: begin
          pronto     <= 1'b0;
          ocupado    <= 1'b0;
          estado_reg <= OCIOSO;
        end
        default: begin
          estado_reg <= OCIOSO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_subtrator_serial.sv
// Scoreboard bench for subtrator_serial (LARGURA=4): stimulus pushes expected
// results with their due cycle, a negedge monitor pops them on every pronto.
module tb_subtrator_serial;

  localparam int L = 4;

  logic         clock = 1'b0;
  logic         reset;
  logic         iniciar;
  logic [L-1:0] numero1;
  logic [L-1:0] numero2;
  logic [L-1:0] resultado;
  logic         negativo;
  logic         ocupado;
  logic         pronto;

  subtrator_serial #(.LARGURA(L)) dut (
    .clock     (clock),
    .reset     (reset),
    .iniciar   (iniciar),
    .numero1   (numero1),
    .numero2   (numero2),
    .resultado (resultado),
    .negativo  (negativo),
    .ocupado   (ocupado),
    .pronto    (pronto)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [L-1:0] res;
    logic         neg;
    int           due;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   chk_cnt = 0;
  int   pass_cnt = 0;
  logic prev_pronto = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int expv);
    chk_cnt++;
    if (act == expv) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, expv, cyc);
  endtask

  // Monitor: every pronto must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (pronto) begin
      exp_t e;
      chk("pronto_single_cycle", int'(prev_pronto), 0);
      if (q.size() == 0) begin
        chk("unexpected_pronto", 1, 0);
      end else begin
        e = q.pop_front();
        chk("resultado", int'(resultado), int'(e.res));
        chk("negativo", int'(negativo), int'(e.neg));
        chk("latency_cycle", cyc, e.due);
        $display("pronto at cycle %0d: resultado=%h negativo=%0d", cyc, resultado, negativo);
      end
    end
    prev_pronto <= pronto;
  end

  // Issue one start (iniciar high for one edge); optionally log an expectation.
  task automatic start(input logic [L-1:0] a, input logic [L-1:0] b,
                       input logic [L-1:0] r, input logic n, input bit push);
    exp_t e;
    iniciar = 1'b1;
    numero1 = a;
    numero2 = b;
    if (push) begin
      e.res = r;
      e.neg = n;
      e.due = cyc + 1 + L;
      q.push_back(e);
    end
    @(posedge clock); #1;
    iniciar = 1'b0;
    numero1 = $urandom_range(15, 0);
    numero2 = $urandom_range(15, 0);
  endtask

  // Wait for ocupado to drop; returns how many sampled cycles it was high.
  task automatic wait_idle(output int n);
    n = 0;
    for (int i = 0; i < 20 && ocupado; i++) begin
      n++;
      @(posedge clock); #1;
    end
    if (ocupado) chk("idle_timeout", 1, 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_resultado"}, int'(resultado), 0);
    chk({tag, "_negativo"}, int'(negativo), 0);
    chk({tag, "_ocupado"}, int'(ocupado), 0);
    chk({tag, "_pronto"}, int'(pronto), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [L-1:0] mr;
    reset   = 1'b1;
    iniciar = 1'b0;
    numero1 = '0;
    numero2 = '0;
    repeat (2) @(posedge clock);
    #1;
    check_zero("reset");
    reset = 1'b0;

    // 9 - 3, with ocupado width check
    start(4'd9, 4'd3, 4'd6, 1'b0, 1'b1);
    wait_idle(n);
    chk("ocupado_cycles", n, 5);

    // Borrow cases and equal operands
    start(4'd3, 4'd9, 4'hA, 1'b1, 1'b1);
    wait_idle(n);
    start(4'd0, 4'd1, 4'hF, 1'b1, 1'b1);
    wait_idle(n);
    start(4'd15, 4'd15, 4'h0, 1'b0, 1'b1);
    wait_idle(n);

    // Start request during CALCULA must be ignored
    start(4'd9, 4'd3, 4'd6, 1'b0, 1'b1);
    @(posedge clock); #1;
    iniciar = 1'b1;
    numero1 = 4'd1;
    numero2 = 4'd2;
    @(posedge clock); #1;
    iniciar = 1'b0;
    wait_idle(n);
    repeat (8) @(posedge clock);
    #1;
    chk("ignored_start_hold", int'(resultado), 6);

    // iniciar held high: accepts at +1, +7, +13 relative to this cycle
    iniciar = 1'b1;
    numero1 = 4'd5;
    numero2 = 4'd2;
    for (int i = 0; i < 3; i++) begin
      exp_t e;
      e.res = 4'd3;
      e.neg = 1'b0;
      e.due = cyc + 1 + L + 6 * i;
      q.push_back(e);
    end
    repeat (13) @(posedge clock);
    #1;
    iniciar = 1'b0;
    wait_idle(n);

    // Reset on the second CALCULA edge aborts with no pronto
    start(4'd12, 4'd5, 4'd7, 1'b0, 1'b0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check_zero("abort");
    repeat (8) @(posedge clock);
    #1;
    start(4'd12, 4'd5, 4'd7, 1'b0, 1'b1);
    wait_idle(n);

    // Exhaustive sweep against the reference model
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        mr = L'((a - b) & 15);
        start(L'(a), L'(b), mr, (a < b), 1'b1);
        wait_idle(n);
      end
    end

    repeat (10) @(posedge clock);
    #1;
    chk("scoreboard_empty", q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
